// File: rtl/write_mask_seq.sv
// write_mask_seq: per-channel SRAM write-mask sequencer.
// A start pulse opens a pass over CH_NUM channels. Each accepted beat writes one
// channel group of ACT_PER_ADDR mask bits: a single lane (mode 0) or all lanes
// (mode 1). The result appears on the SRAM port DELAY cycles after the beat.
// Optional macro WMASK_RANGE_CHK_EN: a mode-0 start whose lane_sel is out of
// range is rejected and reported on cfg_err. Without it, such a start is
// accepted and uses lane 0.
module write_mask_seq #(
  parameter int unsigned CH_NUM       = 24,
  parameter int unsigned ACT_PER_ADDR = 4,
  parameter int unsigned DELAY        = 5,
  localparam int unsigned LANE_W = (ACT_PER_ADDR > 1) ? $clog2(ACT_PER_ADDR) : 1,
  localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
  localparam int unsigned MASK_W = CH_NUM * ACT_PER_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [LANE_W-1:0] lane_sel,
  input  logic              in_valid,
  output logic              sram_wen,
  output logic [MASK_W-1:0] sram_bytemask,
  output logic [CH_W-1:0]   out_ch_idx,
  output logic              done,
  output logic              busy,
  output logic              cfg_err
);

  localparam int unsigned LANE_CNT = 1 << LANE_W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [ACT_PER_ADDR-1:0]   grp_q, grp_d;
  logic                      busy_q;

  logic [LANE_CNT-1:0]       lane_oh_c;
  logic                      lane_oor_c;
  logic                      start_bad_c;
  logic                      start_ok_c;
  logic [ACT_PER_ADDR-1:0]   start_grp_c;

  logic                      beat_valid_c;
  logic [CH_W-1:0]           beat_ch_c;
  logic [ACT_PER_ADDR-1:0]   beat_grp_c;
  logic [ACT_PER_ADDR-1:0]   beat_rev_c;
  logic                      beat_last_c;
  logic [MASK_W-1:0]         beat_mask_c;
  int unsigned               beat_shamt_c;

  logic                      wen_pipe  [DELAY];
  logic [MASK_W-1:0]         mask_pipe [DELAY];
  logic [CH_W-1:0]           ch_pipe   [DELAY];
  logic                      done_pipe [DELAY];

  // Lane decode; a lane index past ACT_PER_ADDR-1 lands in the upper one-hot bits.
  assign lane_oh_c  = LANE_CNT'(1) << lane_sel;
  assign lane_oor_c = |(lane_oh_c >> ACT_PER_ADDR);

`ifdef WMASK_RANGE_CHK_EN
  assign start_bad_c = ~mode & lane_oor_c;
`else
  assign start_bad_c = 1'b0;
`endif

  assign start_ok_c = start & ~start_bad_c;

  // Lane group written per beat for the configuration being sampled at start.
  assign start_grp_c = mode       ? {ACT_PER_ADDR{1'b1}} :
                       lane_oor_c ? ACT_PER_ADDR'(1)     :
                                    lane_oh_c[ACT_PER_ADDR-1:0];

  // State register and per-pass configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      grp_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      grp_q   <= grp_d;
      busy_q  <= (state_d == S_RUN);
    end
  end

  // Next-state, channel counter and beat issue.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    grp_d        = grp_q;
    beat_valid_c = 1'b0;
    beat_ch_c    = ch_q;
    beat_grp_c   = grp_q;
    beat_last_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ok_c) begin
          state_d = S_RUN;
          ch_d    = '0;
          grp_d   = start_grp_c;
        end
        beat_valid_c = in_valid & start_ok_c;
      end
      S_RUN: begin
        if (start_ok_c) begin
          ch_d  = '0;
          grp_d = start_grp_c;
        end
        beat_valid_c = in_valid;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_ok_c) begin
      beat_ch_c  = '0;
      beat_grp_c = start_grp_c;
    end

    beat_last_c = (beat_ch_c == CH_W'(CH_NUM - 1));

    if (beat_valid_c) begin
      if (beat_last_c) begin
        ch_d    = '0;
        state_d = S_IDLE;
      end else begin
        ch_d = beat_ch_c + CH_W'(1);
      end
    end
  end

  // Channel c lane k maps to mask bit MASK_W-1-(c*ACT_PER_ADDR+k): reverse the
  // lane group and shift it into the channel's slot counted from the top.
  assign beat_rev_c   = {<<{beat_grp_c}};
  assign beat_shamt_c = (CH_NUM - 1 - 32'(beat_ch_c)) * ACT_PER_ADDR;
  assign beat_mask_c  = ~(MASK_W'(beat_rev_c) << beat_shamt_c);

  // Output delay line, stored directly in SRAM-port form (idle = no write).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        wen_pipe[i]  <= 1'b1;
        mask_pipe[i] <= '1;
        ch_pipe[i]   <= '0;
        done_pipe[i] <= 1'b0;
      end
    end else begin
      wen_pipe[0]  <= ~beat_valid_c;
      mask_pipe[0] <= beat_valid_c ? beat_mask_c : '1;
      ch_pipe[0]   <= beat_valid_c ? beat_ch_c : '0;
      done_pipe[0] <= beat_valid_c & beat_last_c;
      for (int unsigned i = 1; i < DELAY; i++) begin
        wen_pipe[i]  <= wen_pipe[i-1];
        mask_pipe[i] <= mask_pipe[i-1];
        ch_pipe[i]   <= ch_pipe[i-1];
        done_pipe[i] <= done_pipe[i-1];
      end
    end
  end

`ifdef WMASK_RANGE_CHK_EN
  logic cfg_err_q;

  // One-cycle report of a rejected start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start & start_bad_c;
    end
  end

  assign cfg_err = cfg_err_q;
`else
  assign cfg_err = 1'b0;
`endif

  assign sram_wen      = wen_pipe[DELAY-1];
  assign sram_bytemask = mask_pipe[DELAY-1];
  assign out_ch_idx    = ch_pipe[DELAY-1];
  assign done          = done_pipe[DELAY-1];
  assign busy          = busy_q;

endmodule

// File: tb/tb_write_mask_seq.sv
// Bench for write_mask_seq: table vectors, directed multi-cycle sequences and
// random stimulus against a pass-level reference model.
module tb_write_mask_seq;

  localparam int CH  = 24;
  localparam int ACT = 4;
  localparam int D   = 5;
  localparam int MW  = CH * ACT;
  localparam int MW3 = CH * 3;
  localparam int NC  = 2000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic [1:0] lane_sel = 2'd0;
  logic in_valid = 1'b0;

  logic          sram_wen, done, busy, cfg_err;
  logic [MW-1:0] sram_bytemask;
  logic [4:0]    out_ch_idx;

  logic           sram_wen3, done3, busy3, cfg_err3;
  logic [MW3-1:0] sram_bytemask3;
  logic [4:0]     out_ch_idx3;

  write_mask_seq #(.CH_NUM(CH), .ACT_PER_ADDR(ACT), .DELAY(D)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lane_sel(lane_sel),
    .in_valid(in_valid), .sram_wen(sram_wen), .sram_bytemask(sram_bytemask),
    .out_ch_idx(out_ch_idx), .done(done), .busy(busy), .cfg_err(cfg_err)
  );

  // Three lanes per channel so that lane_sel=3 is out of range.
  write_mask_seq #(.CH_NUM(CH), .ACT_PER_ADDR(3), .DELAY(D)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lane_sel(lane_sel),
    .in_valid(in_valid), .sram_wen(sram_wen3), .sram_bytemask(sram_bytemask3),
    .out_ch_idx(out_ch_idx3), .done(done3), .busy(busy3), .cfg_err(cfg_err3)
  );

  always #5 clk = ~clk;

  // Expected SRAM-port value per cycle, and what the DUT showed.
  logic          e_wen  [NC];
  logic [MW-1:0] e_mask [NC];
  int            e_ch   [NC];
  logic          e_done [NC];
  logic          e_busy;
  logic          l_wen  [NC];
  logic [MW-1:0] l_mask [NC];
  int            l_ch   [NC];
  logic          l_done [NC];
  logic           l3_wen  [NC];
  logic [MW3-1:0] l3_mask [NC];
  logic           l3_busy [NC];
  logic           l3_cfg  [NC];

  // Reference model pass state.
  bit m_run;
  int m_ch;
  bit m_all;
  int m_lane;

  int cyc;
  int n_chk;
  int n_fail;

  typedef struct {
    bit mode;
    int lane;
    int ch;
    int lo;
    int hi;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] bitclr(input int lo, input int hi);
    logic [MW-1:0] m;
    m = '1;
    for (int b = lo; b <= hi; b++) m = m & ~(MW'(1) << b);
    return m;
  endfunction

  function automatic logic [MW3-1:0] bitclr3(input int b);
    logic [MW3-1:0] m;
    m = '1;
    m = m & ~(MW3'(1) << b);
    return m;
  endfunction

  task automatic set_idle(input int t);
    e_wen[t]  = 1'b1;
    e_mask[t] = '1;
    e_ch[t]   = 0;
    e_done[t] = 1'b0;
  endtask

  // Pass-level reference: which channel/lane each beat writes, D cycles later.
  task automatic model(input bit s, input bit m, input int l, input bit v);
    logic [MW-1:0] mk;
    bit bad;
    int t;
`ifdef WMASK_RANGE_CHK_EN
    bad = s && !m && (l >= ACT);
`else
    bad = 1'b0;
`endif
    if (s && !bad) begin
      m_run  = 1'b1;
      m_ch   = 0;
      m_all  = m;
      m_lane = (l >= ACT) ? 0 : l;
    end
    if (v && m_run) begin
      t  = cyc + D;
      mk = '1;
      for (int k = 0; k < ACT; k++)
        if (m_all || k == m_lane) mk = mk & ~(MW'(1) << (MW - 1 - (m_ch * ACT + k)));
      e_wen[t]  = 1'b0;
      e_mask[t] = mk;
      e_ch[t]   = m_ch;
      e_done[t] = (m_ch == CH - 1);
      m_ch++;
      if (m_ch == CH) begin
        m_ch  = 0;
        m_run = 1'b0;
      end
    end
    e_busy = m_run;
  endtask

  task automatic check_outputs();
    l_wen[cyc]   = sram_wen;
    l_mask[cyc]  = sram_bytemask;
    l_ch[cyc]    = int'(out_ch_idx);
    l_done[cyc]  = done;
    l3_wen[cyc]  = sram_wen3;
    l3_mask[cyc] = sram_bytemask3;
    l3_busy[cyc] = busy3;
    l3_cfg[cyc]  = cfg_err3;
    chk("wen", MW'(sram_wen), MW'(e_wen[cyc]));
    chk("mask", sram_bytemask, e_mask[cyc]);
    chk("ch_idx", MW'(out_ch_idx), MW'(e_ch[cyc]));
    chk("done", MW'(done), MW'(e_done[cyc]));
    chk("busy", MW'(busy), MW'(e_busy));
    chk("cfg_err", MW'(cfg_err), '0);
  endtask

  // One clock: drive inputs at the falling edge, check the next cycle's outputs.
  task automatic cycle_io(input bit s, input bit m, input int l, input bit v);
    start    = s;
    mode     = m;
    lane_sel = 2'(l);
    in_valid = v;
    if (rst_n) model(s, m, l, v);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_io(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic rnd_beat();
    cycle_io(1'b0, 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    int t0, t23, t24, tb, tb8, tb9, tg, tr, c0, nw;

    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    m_run  = 1'b0;
    m_ch   = 0;
    m_all  = 1'b0;
    m_lane = 0;
    e_busy = 1'b0;
    for (int t = 0; t < NC; t++) set_idle(t);

    tbl[0] = '{mode: 1'b0, lane: 1, ch: 0,  lo: 94, hi: 94};
    tbl[1] = '{mode: 1'b0, lane: 1, ch: 23, lo: 2,  hi: 2};
    tbl[2] = '{mode: 1'b1, lane: 2, ch: 5,  lo: 72, hi: 75};
    tbl[3] = '{mode: 1'b0, lane: 0, ch: 0,  lo: 95, hi: 95};
    tbl[4] = '{mode: 1'b0, lane: 3, ch: 23, lo: 0,  hi: 0};
    tbl[5] = '{mode: 1'b1, lane: 0, ch: 0,  lo: 92, hi: 95};
    tbl[6] = '{mode: 1'b1, lane: 3, ch: 23, lo: 0,  hi: 3};
    tbl[7] = '{mode: 1'b0, lane: 2, ch: 10, lo: 53, hi: 53};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_wen", MW'(sram_wen), MW'(1));
    chk("rst_mask", sram_bytemask, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    chk("rst_done", MW'(done), '0);
    chk("rst_busy", MW'(busy), '0);
    check_outputs();
    rst_n = 1'b1;

    // Full pass, mode 0 lane 1, followed by one stray beat.
    cycle_io(1'b1, 1'b0, 1, 1'b0);
    t0 = cyc;
    t23 = 0;
    for (int j = 0; j < CH; j++) begin
      if (j == CH - 1) t23 = cyc;
      rnd_beat();
    end
    t24 = cyc;
    rnd_beat();
    idle(D + 2);
    chk("pass_pre_wen", MW'(l_wen[t0+D-1]), MW'(1));
    chk("pass_first_wen", MW'(l_wen[t0+D]), '0);
    chk("pass_first_mask", l_mask[t0+D], bitclr(94, 94));
    chk("pass_last_mask", l_mask[t23+D], bitclr(2, 2));
    chk("pass_last_done", MW'(l_done[t23+D]), MW'(1));
    chk("pass_stray_wen", MW'(l_wen[t24+D]), MW'(1));

    // Table: mask of a chosen channel for a chosen configuration.
    for (int i = 0; i < 8; i++) begin
      cycle_io(1'b1, tbl[i].mode, tbl[i].lane, 1'b0);
      for (int j = 0; j < tbl[i].ch; j++) rnd_beat();
      tb = cyc;
      rnd_beat();
      idle(D + 1);
      chk("tbl_wen", MW'(l_wen[tb+D]), '0);
      chk("tbl_ch", MW'(l_ch[tb+D]), MW'(tbl[i].ch));
      chk("tbl_mask", l_mask[tb+D], bitclr(tbl[i].lo, tbl[i].hi));
    end

    // Gapped beats, then a restart at channel 10 while 8 and 9 drain.
    cycle_io(1'b1, 1'b0, 2, 1'b0);
    tb8 = 0;
    tb9 = 0;
    tg  = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 8) tb8 = cyc;
      if (j == 9) tb9 = cyc;
      rnd_beat();
      if (j == 4) tg = cyc;
      cycle_io(1'b0, 1'($urandom), 0, 1'b0);
    end
    tr = cyc;
    cycle_io(1'b1, 1'b1, 0, 1'b1);
    rnd_beat();
    idle(D + 2);
    chk("gap_wen", MW'(l_wen[tg+D]), MW'(1));
    chk("drain8_ch", MW'(l_ch[tb8+D]), MW'(8));
    chk("drain9_wen", MW'(l_wen[tb9+D]), '0);
    chk("drain9_ch", MW'(l_ch[tb9+D]), MW'(9));
    chk("restart_ch", MW'(l_ch[tr+D]), '0);
    chk("restart_mask", l_mask[tr+D], bitclr(92, 95));

    // Reset with three beats in flight.
    cycle_io(1'b1, 1'b1, 0, 1'b1);
    rnd_beat();
    rnd_beat();
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", MW'(sram_wen), MW'(1));
    chk("mrst_mask", sram_bytemask, '1);
    chk("mrst_done", MW'(done), '0);
    chk("mrst_busy", MW'(busy), '0);
    for (int t = cyc; t < NC; t++) set_idle(t);
    m_run  = 1'b0;
    e_busy = 1'b0;
    cycle_io(1'b0, 1'b0, 0, 1'b0);
    cycle_io(1'b0, 1'b0, 0, 1'b0);
    rst_n = 1'b1;
    nw = 0;
    for (int j = 0; j < D + 3; j++) begin
      rnd_beat();
      if (!l_wen[cyc]) nw++;
    end
    chk("mrst_no_write", MW'(nw), '0);

    // Out-of-range lane at start (only out of range for the 3-lane instance).
    c0 = cyc;
    cycle_io(1'b1, 1'b0, 3, 1'b1);
    idle(D + 2);
    chk("range_main_mask", l_mask[c0+D], bitclr(92, 92));
`ifdef WMASK_RANGE_CHK_EN
    chk("range_cfg_err", MW'(l3_cfg[c0+1]), MW'(1));
    chk("range_cfg_pulse", MW'(l3_cfg[c0+2]), '0);
    chk("range_busy", MW'(l3_busy[c0+1]), '0);
    chk("range_wen", MW'(l3_wen[c0+D]), MW'(1));
`else
    chk("range_cfg_err", MW'(l3_cfg[c0+1]), '0);
    chk("range_busy", MW'(l3_busy[c0+1]), MW'(1));
    chk("range_wen", MW'(l3_wen[c0+D]), '0);
    chk("range_mask", MW'(l3_mask[c0+D]), MW'(bitclr3(71)));
`endif

    // Random traffic against the model.
    for (int j = 0; j < 600; j++) begin
      cycle_io(($urandom_range(0, 29) == 0), 1'($urandom),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    idle(D + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/write_mask_seq.md
WRITE_MASK_SEQ -- requirements
Module: write_mask_seq

Interface
REQ-001 SHALL have parameter CH_NUM, default 24, number of channels per SRAM word.
REQ-002 SHALL have parameter ACT_PER_ADDR, default 4, activations per channel per word.
REQ-003 SHALL have parameter DELAY, default 5, output pipeline depth in cycles; legal range is DELAY >= 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle pulse that begins a channel pass.
REQ-007 SHALL have port mode, input, 1: 0 = single lane; 1 = all ACT_PER_ADDR lanes of the channel.
REQ-008 SHALL have port lane_sel, input, $clog2(ACT_PER_ADDR), lane within the channel group.
REQ-009 SHALL have port in_valid, input, 1, datapath beat request.
REQ-010 SHALL have port sram_wen, output, 1, active-low SRAM write enable.
REQ-011 SHALL have port sram_bytemask, output, CH_NUM*ACT_PER_ADDR, active-low mask; 0 = bit written.
REQ-012 SHALL have port out_ch_idx, output, $clog2(CH_NUM), channel of the current output beat.
REQ-013 SHALL have port done, output, 1, pulse coincident with the last write of a pass.
REQ-014 SHALL have port busy, output, 1, high while a pass is in state RUN.
REQ-015 SHALL have port cfg_err, output, 1, configuration error pulse.

Function
REQ-016 SHALL implement a two-state FSM: IDLE to RUN on an accepted start; RUN to IDLE on the beat for channel CH_NUM-1.
REQ-017 SHALL sample mode and lane_sel on an accepted start and hold them for the whole pass.
REQ-018 SHALL keep a channel counter ch_cnt that is set to 0 on start and incremented by 1 on each accepted beat.
REQ-019 SHALL accept a beat when in_valid=1 and either the FSM is in RUN or start=1 in the same cycle.
REQ-020 SHALL, when start and in_valid are both 1 in the same cycle, issue the beat for channel 0 and leave ch_cnt at 1.
REQ-021 SHALL, on start while in RUN, restart the pass; the next beat uses channel 0, and beats already in the pipeline still complete.
REQ-022 SHALL ignore in_valid in IDLE when start=0: no write is issued.
REQ-023 SHALL wrap ch_cnt to 0 on the beat for channel CH_NUM-1 and tag that beat as last.
REQ-024 SHALL, in mode 0, clear only bit (CH_NUM*ACT_PER_ADDR-1) - (c*ACT_PER_ADDR + lane) of sram_bytemask for channel c; all other bits are 1.
REQ-025 SHALL, in mode 1, clear bits (CH_NUM*ACT_PER_ADDR-1) - (c*ACT_PER_ADDR + k) for k = 0 .. ACT_PER_ADDR-1; lane_sel is ignored.
REQ-026 SHALL present sram_wen=0, sram_bytemask, out_ch_idx and done for an accepted beat exactly DELAY clock edges after the beat's cycle.
REQ-027 SHALL drive sram_wen=1, sram_bytemask all ones, done=0 and out_ch_idx=0 in every output cycle with no beat.
REQ-028 SHALL sustain one beat per cycle with no bubbles inserted.

Reset
REQ-029 SHALL, on rst_n=0, asynchronously force: FSM IDLE, ch_cnt=0, busy=0, sram_wen=1, sram_bytemask all ones, out_ch_idx=0, done=0, cfg_err=0.
REQ-030 SHALL, on reset mid-pass, discard all in-flight pipeline beats; none appears after reset is released.

Configuration
REQ-031 SHALL, with macro WMASK_RANGE_CHK_EN defined, reject a start with mode=0 and lane_sel >= ACT_PER_ADDR: no state change, and a one-cycle cfg_err=1 on the next cycle.
REQ-032 SHALL, without WMASK_RANGE_CHK_EN, accept such a start, use lane 0, and tie cfg_err to 0.

Verification
REQ-033 SHALL cover reset: rst_n=0 -> sram_wen=1, sram_bytemask=96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, done=0, busy=0.
REQ-034 SHALL cover a full pass: start with mode=0, lane_sel=1, then 24 back-to-back in_valid beats -> first write 5 cycles later with only bit 94 clear; last write has only bit 2 clear with done=1; a 25th in_valid gives no write.
REQ-035 SHALL cover mode 1: start with mode=1, beat for channel 5 -> bits 75..72 clear, all others 1, out_ch_idx=5.
REQ-036 SHALL cover gapped beats and restart: in_valid gaps give no writes in the gap cycles; start at ch_cnt=10 -> the next beat writes channel 0, and earlier beats 8 and 9 still drain.
REQ-037 SHALL cover reset mid-pass: rst_n=0 with 3 beats in flight -> outputs reset immediately, and no writes follow after release.
REQ-038 SHALL cover the range check: mode=0, lane_sel=3 with ACT_PER_ADDR=3 -> with the macro, cfg_err pulse and busy=0; without it, channel 0 clears bit 71.
